// File: rtl/prienc_pkg.sv
// Shared constants, state encoding and bit-count helper for the 16-to-4 priority encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prienc_pkg;

    localparam int WIDTH  = 16;
    localparam int CODE_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Number of set bits in a request vector; CODE_W+1 bits so a full vector (WIDTH) fits.
    function automatic logic [CODE_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [CODE_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{CODE_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/find_first16.sv
// Combinational search for the winning set bit of a vector (lowest index, or highest with PRIO_MSB_FIRST_EN).
// Latency: zero cycles, purely combinational.
// Backpressure: none; any=0 flags an empty vector, idx is then 0.
module find_first16
    import prienc_pkg::*;
(
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Scan so that the last hit written is the winning bit for the selected direction.
    always_comb begin
        idx = '0;
        any = |vec;
`ifdef PRIO_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/priority_encoder16.sv
// Captures a 16-bit request vector and emits each set bit's index, one code per ack (optional macro PRIO_MSB_FIRST_EN flips order to MSB first).
// Latency: code/valid registered, valid the cycle after load; one code per cycle with ack held high.
// Backpressure: with ack low all outputs hold; load is ignored while busy.
module priority_encoder16
    import prienc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  req_in,
    input  logic              load,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ack,
    output logic              busy,
    output logic [CODE_W:0]   remaining
);

    state_t            state_q, state_n;
    logic [WIDTH-1:0]  pend_q, pend_n;
    logic [CODE_W-1:0] code_q, code_n;
    logic [CODE_W:0]   rem_q, rem_n;

    logic [CODE_W-1:0] load_idx, next_idx;
    logic              load_any, next_any;
    logic [WIDTH-1:0]  pend_cleared;

    // Pending set with the currently presented bit removed, as it will be after an ack.
    assign pend_cleared = pend_q & ~(WIDTH'(1) << code_q);

    find_first16 u_ff_load (
        .vec (req_in),
        .idx (load_idx),
        .any (load_any)
    );

    find_first16 u_ff_next (
        .vec (pend_cleared),
        .idx (next_idx),
        .any (next_any)
    );

    // Next-state logic: capture on load in IDLE, advance to the next bit on ack in PRESENT.
    always_comb begin
        state_n = state_q;
        pend_n  = pend_q;
        code_n  = code_q;
        rem_n   = rem_q;
        case (state_q)
            IDLE: begin
                if (load && load_any) begin
                    pend_n  = req_in;
                    code_n  = load_idx;
                    rem_n   = popcount(req_in);
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    pend_n = pend_cleared;
                    rem_n  = rem_q - 1'b1;
                    if (next_any) begin
                        code_n = next_idx;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State registers with synchronous reset that discards any pending requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_n;
            pend_q  <= pend_n;
            code_q  <= code_n;
            rem_q   <= rem_n;
        end
    end

    assign busy      = (state_q == PRESENT);
    assign valid     = busy;
    assign code      = code_q;
    assign remaining = rem_q;

endmodule

// File: doc/priority_encoder16.md
Name: priority_encoder16

Overview:
- Sequential 16-to-4 encoder; the inverse of the 4-to-16 timing/opcode decoder.
- Captures a 16-bit request vector, for example flag or interrupt lines from the Basic Computer datapath.
- Emits the index of each set bit as a 4-bit code, one code per handshake, until no requests remain.
- Sits between flag/request sources and control logic that consumes a binary code.

Parameters:
- WIDTH, 16, number of request lines.
- CODE_W, 4, code width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  WIDTH  request vector, sampled when load=1 in IDLE.
- load  input  1  capture strobe for req_in.
- code  output  CODE_W  registered index of the current request.
- valid  output  1  code holds a pending request.
- ack  input  1  consumer accepts code; effective only while valid=1.
- busy  output  1  block is in PRESENT state.
- remaining  output  CODE_W+1  number of set bits still pending, including the one on code.

Behaviour:
- Reset, sampled on a clk edge with rst=1: pend=0, code=0, valid=0, busy=0, remaining=0, state=IDLE. Reset overrides all other inputs, including mid-operation; pending requests are discarded.
- States are IDLE and PRESENT.
- IDLE, edge with load=1 and req_in!=0:
  - pend<=req_in, code<=lowest set index of req_in, valid<=1, remaining<=popcount(req_in).
  - state<=PRESENT. Latency: outputs valid the cycle after load.
- IDLE, load=1 and req_in=0: no change; stays IDLE with valid=0.
- IDLE, ack=1: ignored.
- PRESENT, edge with ack=1:
  - pend<=pend with bit[code] cleared; remaining<=remaining-1.
  - If the new pend is nonzero: code<=its lowest set index, valid stays 1. Throughput is one code per cycle with ack held high.
  - If the new pend is zero: valid<=0, code holds its last value, state<=IDLE. load is accepted again on the following edge.
- PRESENT, ack=0: all outputs hold.
- PRESENT, load=1: ignored, whether or not ack is high; ack takes effect normally.
- busy equals (state==PRESENT); valid equals busy.
- Lowest index wins: bit 0 has the highest priority.
- Width rules:
  - remaining ranges 0..WIDTH; WIDTH=16 needs 5 bits.
  - code never wraps; only indices 0..WIDTH-1 are produced.

Optional Feature:
- Macro: PRIO_MSB_FIRST_EN.
- Defined: highest set index wins. Bit 15 has top priority, and codes are emitted in descending order.
- Undefined: lowest set index wins, as specified above.
- Port list, latency and handshake are identical in both builds.

Decomposition:
- Package prienc_pkg:
  - WIDTH and CODE_W constants.
  - State enum {IDLE, PRESENT}.
  - Function popcount(WIDTH) returning CODE_W+1 bits.
- Sub-module find_first16: purely combinational.
  - Inputs: vec[WIDTH].
  - Outputs: idx[CODE_W] and any (vec!=0).
  - Direction is selected by PRIO_MSB_FIRST_EN.
  - Instantiated twice: once on req_in for the load path, once on the cleared pend for the ack path.

Test Plan:
- Reset with random inputs, then load req_in=16'h0000 → valid=0, busy=0, remaining=0, no state change.
- load 16'h8421, ack held high → valid from the next cycle; codes 0,5,10,15 on consecutive cycles; remaining 4,3,2,1; valid drops after the fourth ack; busy=0.
- load 16'h0100, ack low for 5 cycles, then pulse → code=8 held stable through the stall; one ack returns to IDLE.
- While PRESENT on 16'h0003, assert load with 16'hFFFF → ignored; codes 0 then 1 only; remaining 2→1→0.
- Assert rst mid-sequence after the first ack of 16'hF000 → next cycle valid=0, remaining=0; a fresh load 16'h0010 yields code=4.
- Build with PRIO_MSB_FIRST_EN, load 16'h8421, ack high → codes 15,10,5,0.
